// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// aes_pkg : key-length encoding, schedule lookups, Rcon and S-box helpers
// Rev 1.0
// ============================================================================
package aes_pkg;

  typedef enum logic [1:0] {
    KL_128 = 2'b00,
    KL_192 = 2'b01,
    KL_256 = 2'b10,
    KL_BAD = 2'b11
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PRE  = 2'd1,
    ST_FWD  = 2'd2,
    ST_REV  = 2'd3
  } ks_state_e;

  // x^254 is the multiplicative inverse in GF(2^8), with 0 mapping to 0
  localparam logic [7:0] C_INV_EXP = 8'hFE;

  function automatic logic [3:0] nk_of(logic [1:0] len);
    case (len)
      KL_128:  return 4'd4;
      KL_192:  return 4'd6;
      default: return 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(logic [1:0] len);
    case (len)
      KL_128:  return 4'd10;
      KL_192:  return 4'd12;
      default: return 4'd14;
    endcase
  endfunction

  function automatic logic [5:0] tw_of(logic [1:0] len);
    case (len)
      KL_128:  return 6'd44;
      KL_192:  return 6'd52;
      default: return 6'd60;
    endcase
  endfunction

  function automatic logic len_legal(logic [1:0] len, int max_bits);
    return (len != KL_BAD) && ((32 * int'(nk_of(len))) <= max_bits);
  endfunction

  function automatic logic [7:0] rcon(logic [5:0] q);
    case (q)
      6'd1:    return 8'h01;
      6'd2:    return 8'h02;
      6'd3:    return 8'h04;
      6'd4:    return 8'h08;
      6'd5:    return 8'h10;
      6'd6:    return 8'h20;
      6'd7:    return 8'h40;
      6'd8:    return 8'h80;
      6'd9:    return 8'h1b;
      6'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] gf_mul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(logic [7:0] x);
    logic [7:0] inv;
    logic [7:0] b;
    inv = 8'h01;
    b   = x;
    for (int k = 0; k < 8; k++) begin
      if (C_INV_EXP[k]) inv = gf_mul(inv, b);
      b = gf_mul(b, b);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_ks_word_fn.sv
`default_nettype none
// ============================================================================
// aes_ks_word_fn : combinational key-schedule word transform f(x, i, Nk)
// Rev 1.0
// ============================================================================
module aes_ks_word_fn
  import aes_pkg::*;
(
  input  logic [31:0] i_x,
  input  logic [5:0]  i_idx,
  input  logic [3:0]  i_nk,
  output logic [31:0] o_y
);

  logic [5:0] w_q;
  logic [5:0] w_m;

  always_comb begin
    w_q = 6'd0;
    w_m = 6'd0;
    o_y = i_x;
    case (i_nk)
      4'd4:    w_q = i_idx >> 2;
      4'd6:    w_q = i_idx / 6'd6;
      default: w_q = i_idx >> 3;
    endcase
    w_m = i_idx - (w_q * {2'b00, i_nk});
    if (w_m == 6'd0) begin
      o_y = sub_word({i_x[23:0], i_x[31:24]}) ^ {rcon(w_q), 24'h000000};
    end else if ((i_nk == 4'd8) && (w_m == 6'd4)) begin
      o_y = sub_word(i_x);
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_key_sched_gen.sv
`default_nettype none
// ============================================================================
// aes_key_sched_gen : 128/192/256-bit AES key scheduler streaming round keys
//                     in ascending or descending round order
// Rev 1.0
// ============================================================================
module aes_key_sched_gen
  import aes_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load_valid,
  output logic         o_load_ready,
  input  logic [255:0] i_load_key,
  input  logic [1:0]   i_load_len,
  input  logic         i_load_dec,
  input  logic         i_flush,
  output logic         o_rk_valid,
  input  logic         i_rk_ready,
  output logic [127:0] o_rk_data,
  output logic [3:0]   o_rk_round,
  output logic         o_load_err
);

  localparam int DEPTH = MAX_KEY_BITS / 32;

  ks_state_e    r_state;
  ks_state_e    w_state_nxt;
  logic [31:0]  r_win [DEPTH];
  logic [31:0]  w_win_nxt [DEPTH];
  logic [3:0]   r_nk;
  logic [3:0]   r_nr;
  logic [5:0]   r_tw;
  logic [5:0]   r_j;
  logic [5:0]   r_cnt;
  logic [31:0]  r_acc [3];
  logic [1:0]   r_acc_n;
  logic [3:0]   r_rnd;
  logic         r_rk_valid;
  logic [127:0] r_rk_data;
  logic [3:0]   r_rk_round;
  logic         r_load_err;

  logic         w_load_ok;
  logic         w_len_ok;
  logic         w_start;
  logic         w_stall;
  logic         w_emit;
  logic         w_fwd_step;
  logic         w_rev_step;
  logic         w_rk_hs;
  logic         w_last;
  logic         w_pre_done;
  logic [31:0]  w_top;
  logic [31:0]  w_sec;
  logic [6:0]   w_sum7;
  logic [31:0]  w_fn_x;
  logic [5:0]   w_fn_idx;
  logic [31:0]  w_fn_y;
  logic         w_fwd_ok;
  logic         w_rev_ok;
  logic [31:0]  w_word;

  assign o_load_ready = (r_state == ST_IDLE);
  assign o_rk_valid   = r_rk_valid;
  assign o_rk_data    = r_rk_data;
  assign o_rk_round   = r_rk_round;
  assign o_load_err   = r_load_err;

  assign w_load_ok  = i_load_valid && (r_state == ST_IDLE) && !i_flush;
  assign w_len_ok   = len_legal(i_load_len, MAX_KEY_BITS);
  assign w_start    = w_load_ok && w_len_ok;
  assign w_stall    = r_rk_valid && !i_rk_ready;
  assign w_rk_hs    = r_rk_valid && i_rk_ready;
  assign w_emit     = ((r_state == ST_FWD) || (r_state == ST_REV)) && (r_cnt != r_tw) && !w_stall;
  assign w_fwd_step = (r_state == ST_PRE) || (w_emit && (r_state == ST_FWD));
  assign w_rev_step = w_emit && (r_state == ST_REV);
  assign w_last     = w_rk_hs && (r_cnt == r_tw);
  assign w_pre_done = (r_cnt == (r_tw - {2'b00, r_nk} - 6'd1));

  always_comb begin
    w_top = 32'h0;
    w_sec = 32'h0;
    for (int k = 0; k < DEPTH; k++) begin
      if (k == int'(r_nk) - 1) w_top = r_win[k];
      if (k == int'(r_nk) - 2) w_sec = r_win[k];
    end
  end

  // One transform instance serves both directions; only the taps differ
  assign w_sum7   = {1'b0, r_j} + {3'b000, r_nk};
  assign w_fn_x   = w_rev_step ? w_sec : w_top;
  assign w_fn_idx = w_rev_step ? 6'(w_sum7 - 7'd1) : w_sum7[5:0];
  assign w_fwd_ok = (w_sum7 < {1'b0, r_tw});
  assign w_rev_ok = (r_j != 6'd0);
  assign w_word   = (r_state == ST_FWD) ? r_win[0] : w_top;

  aes_ks_word_fn u_word_fn (
    .i_x   (w_fn_x),
    .i_idx (w_fn_idx),
    .i_nk  (r_nk),
    .o_y   (w_fn_y)
  );

  always_comb begin
    w_win_nxt = r_win;
    if (i_flush) begin
      for (int k = 0; k < DEPTH; k++) w_win_nxt[k] = 32'h0;
    end else if (w_start) begin
      for (int k = 0; k < DEPTH; k++)
        w_win_nxt[k] = (k < int'(nk_of(i_load_len))) ? i_load_key[255-32*k -: 32] : 32'h0;
    end else if (w_fwd_step) begin
      for (int k = 0; k < DEPTH - 1; k++)
        if (k < int'(r_nk) - 1) w_win_nxt[k] = r_win[k+1];
      for (int k = 0; k < DEPTH; k++)
        if (k == int'(r_nk) - 1) w_win_nxt[k] = w_fwd_ok ? (r_win[0] ^ w_fn_y) : 32'h0;
    end else if (w_rev_step) begin
      for (int k = 1; k < DEPTH; k++)
        if (k < int'(r_nk)) w_win_nxt[k] = r_win[k-1];
      w_win_nxt[0] = w_rev_ok ? (w_top ^ w_fn_y) : 32'h0;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_start) w_state_nxt = i_load_dec ? ST_PRE : ST_FWD;
        ST_PRE:  if (w_pre_done) w_state_nxt = ST_REV;
        ST_FWD,
        ST_REV:  if (w_last) w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) r_win[k] <= 32'h0;
      for (int k = 0; k < 3; k++) r_acc[k] <= 32'h0;
      r_nk       <= 4'd0;
      r_nr       <= 4'd0;
      r_tw       <= 6'd0;
      r_j        <= 6'd0;
      r_cnt      <= 6'd0;
      r_acc_n    <= 2'd0;
      r_rnd      <= 4'd0;
      r_rk_valid <= 1'b0;
      r_rk_data  <= 128'h0;
      r_rk_round <= 4'd0;
      r_load_err <= 1'b0;
    end else begin
      r_win <= w_win_nxt;
      if (i_flush) begin
        r_j        <= 6'd0;
        r_cnt      <= 6'd0;
        r_acc_n    <= 2'd0;
        r_rk_valid <= 1'b0;
        r_rk_data  <= 128'h0;
        r_load_err <= 1'b0;
      end else begin
        r_load_err <= w_load_ok && !w_len_ok;
        if (w_start) begin
          r_nk    <= nk_of(i_load_len);
          r_nr    <= nr_of(i_load_len);
          r_tw    <= tw_of(i_load_len);
          r_j     <= 6'd0;
          r_cnt   <= 6'd0;
          r_acc_n <= 2'd0;
          r_rnd   <= i_load_dec ? nr_of(i_load_len) : 4'd0;
        end
        if (w_fwd_step) r_j <= r_j + 6'd1;
        if (w_rev_step && w_rev_ok) r_j <= r_j - 6'd1;
        if (r_state == ST_PRE) r_cnt <= w_pre_done ? 6'd0 : r_cnt + 6'd1;
        if (w_emit) r_cnt <= r_cnt + 6'd1;
        if (w_rk_hs) r_rk_valid <= 1'b0;
        // A consumed key frees the output, so the next word lands in the same cycle
        if (w_emit) begin
          if (r_acc_n == 2'd3) begin
            r_rk_valid <= 1'b1;
            r_rk_data  <= (r_state == ST_FWD) ? {r_acc[0], r_acc[1], r_acc[2], w_word}
                                              : {w_word, r_acc[2], r_acc[1], r_acc[0]};
            r_rk_round <= r_rnd;
            r_rnd      <= (r_state == ST_FWD) ? r_rnd + 4'd1 : r_rnd - 4'd1;
            r_acc_n    <= 2'd0;
          end else begin
            r_acc[r_acc_n] <= w_word;
            r_acc_n        <= r_acc_n + 2'd1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_sched_gen.sv
`default_nettype none
// ============================================================================
// tb_aes_key_sched_gen : round-key stream checked against a FIPS-197 style
//                        key expansion model
// Rev 1.0
// ============================================================================
module tb_aes_key_sched_gen;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         i_load_valid = 1'b0;
  logic         o_load_ready;
  logic [255:0] i_load_key = '0;
  logic [1:0]   i_load_len = 2'b00;
  logic         i_load_dec = 1'b0;
  logic         i_flush = 1'b0;
  logic         o_rk_valid;
  logic         i_rk_ready = 1'b1;
  logic [127:0] o_rk_data;
  logic [3:0]   o_rk_round;
  logic         o_load_err;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [7:0]  sb [256];
  logic [31:0] mw [60];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  localparam logic [127:0] R128_1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R128_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] R192_12 = 128'he98ba06f448c773c8ecc720401002202;
  localparam logic [127:0] R256_14 = 128'hfe4890d1e6188d0b046df344706c631e;

  aes_key_sched_gen #(.MAX_KEY_BITS(256)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_valid (i_load_valid),
    .o_load_ready (o_load_ready),
    .i_load_key   (i_load_key),
    .i_load_len   (i_load_len),
    .i_load_dec   (i_load_dec),
    .i_flush      (i_flush),
    .o_rk_valid   (o_rk_valid),
    .i_rk_ready   (i_rk_ready),
    .o_rk_data    (o_rk_data),
    .o_rk_round   (o_rk_round),
    .o_load_err   (o_load_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rotl8(logic [7:0] v, int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box built by walking generator 3 and its inverse through the field
  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    for (int n = 0; n < 255; n++) begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
      sb[p] = x ^ 8'h63;
    end
    sb[0] = 8'h63;
  endtask

  function automatic logic [31:0] subw(logic [31:0] x);
    return {sb[x[31:24]], sb[x[23:16]], sb[x[15:8]], sb[x[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] key, input logic [1:0] len,
                              output int nk, output int nr, output int tw);
    logic [31:0] t;
    logic [7:0]  rc;
    nk = (len == 2'd0) ? 4 : (len == 2'd1) ? 6 : 8;
    nr = nk + 6;
    tw = 4 * (nr + 1);
    for (int i = 0; i < nk; i++) mw[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < tw; i++) begin
      t = mw[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = subw(t);
      end
      mw[i] = mw[i-nk] ^ t;
    end
  endtask

  function automatic logic [127:0] rk_model(int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic run_key(input string tag, input logic [255:0] key, input logic [1:0] len,
                         input logic dec, input int stall_pct,
                         input int kra, input logic [127:0] kva,
                         input int krb, input logic [127:0] kvb);
    int nk, nr, tw, idx, k_edge, lat0, r;
    logic seen;
    model_expand(key, len, nk, nr, tw);
    lat0 = dec ? (tw - nk + 4) : 4;
    @(negedge clk);
    chk({tag, " load_ready"}, 128'(o_load_ready), 128'd1);
    i_load_valid = 1'b1;
    i_load_key   = key;
    i_load_len   = len;
    i_load_dec   = dec;
    i_rk_ready   = (stall_pct == 0);
    @(negedge clk);
    i_load_valid = 1'b0;
    k_edge = cyc;
    idx = 0;
    seen = 1'b0;
    for (int c = 0; c < 700 && idx <= nr; c++) begin
      if (o_rk_valid) begin
        r = dec ? nr - idx : idx;
        chk({tag, " rk_data"}, o_rk_data, rk_model(r));
        chk({tag, " rk_round"}, 128'(o_rk_round), 128'(r));
        if (!seen) begin
          seen = 1'b1;
          if (stall_pct == 0)
            chk({tag, " latency"}, 128'(cyc - k_edge), 128'(lat0 + 4 * idx));
          if (r == kra) chk({tag, " known_a"}, o_rk_data, kva);
          if (r == krb) chk({tag, " known_b"}, o_rk_data, kvb);
        end
      end
      i_rk_ready = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
      if (o_rk_valid && i_rk_ready) begin
        idx++;
        seen = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, " keys_done"}, 128'(idx), 128'(nr + 1));
    chk({tag, " idle_after"}, {126'd0, o_load_ready, o_rk_valid}, 128'b10);
    i_rk_ready = 1'b1;
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    build_sbox();
    repeat (3) @(negedge clk);
    chk("reset rk_valid", 128'(o_rk_valid), 128'd0);
    chk("reset rk_data", o_rk_data, 128'd0);
    chk("reset rk_round", 128'(o_rk_round), 128'd0);
    chk("reset load_err", 128'(o_load_err), 128'd0);
    chk("reset load_ready", 128'(o_load_ready), 128'd1);
    rst_n = 1'b1;
    @(negedge clk);

    run_key("aes128_fwd", K128, 2'd0, 1'b0, 0, 1, R128_1, 10, R128_10);
    run_key("aes128_dec", K128, 2'd0, 1'b1, 0, 10, R128_10, 0, K128[255:128]);
    run_key("aes192_fwd", K192, 2'd1, 1'b0, 0, 12, R192_12, 0, K192[255:128]);
    run_key("aes192_dec", K192, 2'd1, 1'b1, 0, 12, R192_12, 0, K192[255:128]);
    run_key("aes256_fwd", K256, 2'd2, 1'b0, 0, 14, R256_14, 0, K256[255:128]);
    run_key("aes256_dec", K256, 2'd2, 1'b1, 0, 14, R256_14, 1, K256[127:0]);
    run_key("aes128_bp", K128, 2'd0, 1'b0, 40, 1, R128_1, 10, R128_10);

    for (int l = 0; l < 3; l++)
      for (int d = 0; d < 2; d++)
        run_key("random", rand_key(), 2'(l), 1'(d), 25, -1, 128'd0, -1, 128'd0);

    // illegal key length
    @(negedge clk);
    i_load_valid = 1'b1;
    i_load_len   = 2'b11;
    @(negedge clk);
    i_load_valid = 1'b0;
    chk("badlen load_err", 128'(o_load_err), 128'd1);
    chk("badlen load_ready", 128'(o_load_ready), 128'd1);
    @(negedge clk);
    chk("badlen err_pulse", 128'(o_load_err), 128'd0);
    repeat (8) @(negedge clk);
    chk("badlen no_rk", 128'(o_rk_valid), 128'd0);

    // load coincident with flush is dropped
    i_load_valid = 1'b1;
    i_load_len   = 2'b00;
    i_load_dec   = 1'b0;
    i_flush      = 1'b1;
    @(negedge clk);
    i_load_valid = 1'b0;
    i_flush      = 1'b0;
    chk("flushload ready", 128'(o_load_ready), 128'd1);
    chk("flushload err", 128'(o_load_err), 128'd0);
    repeat (6) @(negedge clk);
    chk("flushload no_rk", 128'(o_rk_valid), 128'd0);

    // flush in the middle of a descending stream
    i_load_valid = 1'b1;
    i_load_key   = rand_key();
    i_load_len   = 2'b10;
    i_load_dec   = 1'b1;
    i_rk_ready   = 1'b0;
    @(negedge clk);
    i_load_valid = 1'b0;
    repeat (60) @(negedge clk);
    chk("midrev rk_valid", 128'(o_rk_valid), 128'd1);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    chk("flush rk_valid", 128'(o_rk_valid), 128'd0);
    chk("flush load_ready", 128'(o_load_ready), 128'd1);
    i_rk_ready = 1'b1;
    run_key("post_flush", K128, 2'd0, 1'b1, 0, 10, R128_10, 0, K128[255:128]);

    // asynchronous reset mid-stream
    @(negedge clk);
    i_load_valid = 1'b1;
    i_load_key   = K192;
    i_load_len   = 2'b01;
    i_load_dec   = 1'b0;
    i_rk_ready   = 1'b0;
    @(negedge clk);
    i_load_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("prerst rk_valid", 128'(o_rk_valid), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst rk_valid", 128'(o_rk_valid), 128'd0);
    chk("arst rk_data", o_rk_data, 128'd0);
    chk("arst load_ready", 128'(o_load_ready), 128'd1);
    @(negedge clk);
    rst_n = 1'b1;
    i_rk_ready = 1'b1;
    run_key("post_rst", K256, 2'd2, 1'b0, 0, 14, R256_14, 0, K256[255:128]);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
